// File: rtl/queue_word_packer.sv
// Pops bytes from an 8-bit queue and packs BYTES_PER_WORD of them little-endian into one word; `PACKER_FLUSH_EN adds partial-word flush.
// Latency: word_valid rises two cycles after the pop of the last byte; minimum cadence is one word per BYTES_PER_WORD+2 cycles.
// Backpressure: a held word blocks further pops until word_ready is seen; word_ready never reaches q_re combinationally.
module queue_word_packer #(
    parameter int BYTES_PER_WORD = 4,
    parameter int CNT_W          = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        q_empty,
    input  logic [7:0]                  q_data,
    output logic                        q_re,
    output logic [8*BYTES_PER_WORD-1:0] word_out,
    output logic                        word_valid,
    input  logic                        word_ready,
    output logic [CNT_W-1:0]            words_emitted
`ifdef PACKER_FLUSH_EN
    ,
    input  logic                        flush,
    output logic [3:0]                  word_bytes
`endif
);

    typedef enum logic {S_FILL, S_HOLD} state_t;

    state_t                      r_state;
    logic [3:0]                  r_count;
    logic                        r_pending;
    logic [8*BYTES_PER_WORD-1:0] r_word;
    logic                        r_valid;
    logic [CNT_W-1:0]            r_emitted;

    logic [3:0] w_inflight;
    logic       w_room;
    logic       w_last;
    logic       w_accept;
    logic       w_flush_block;

`ifdef PACKER_FLUSH_EN
    logic       r_flush_req;
    logic [3:0] r_word_bytes;

    assign w_flush_block = r_flush_req;
    assign word_bytes    = r_word_bytes;
`else
    assign w_flush_block = 1'b0;
`endif

    // Bytes already captured plus the one in flight must leave room for another pop.
    assign w_inflight = r_count + {3'b000, r_pending};
    assign w_room     = (w_inflight < 4'(BYTES_PER_WORD));
    assign w_last     = r_pending && (r_count == 4'(BYTES_PER_WORD - 1));
    assign w_accept   = r_valid && word_ready;

    assign q_re          = (r_state == S_FILL) && !q_empty && w_room && !w_flush_block;
    assign word_out      = r_word;
    assign word_valid    = r_valid;
    assign words_emitted = r_emitted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_FILL;
            r_count      <= 4'd0;
            r_pending    <= 1'b0;
            r_word       <= '0;
            r_valid      <= 1'b0;
            r_emitted    <= '0;
`ifdef PACKER_FLUSH_EN
            r_flush_req  <= 1'b0;
            r_word_bytes <= 4'd0;
`endif
        end else begin
            r_pending <= q_re;
            case (r_state)
                S_FILL: begin
                    if (r_pending) begin
                        r_word[8*r_count +: 8] <= q_data;
                        r_count                <= r_count + 4'd1;
                    end
                    if (w_last) begin
                        r_state <= S_HOLD;
                        r_valid <= 1'b1;
`ifdef PACKER_FLUSH_EN
                        r_flush_req  <= 1'b0;
                        r_word_bytes <= 4'(BYTES_PER_WORD);
`endif
                    end
`ifdef PACKER_FLUSH_EN
                    // A flushed word waits for its in-flight byte before it is presented.
                    else if (r_flush_req && !r_pending) begin
                        r_state      <= S_HOLD;
                        r_valid      <= 1'b1;
                        r_flush_req  <= 1'b0;
                        r_word_bytes <= r_count;
                    end else if (flush && (w_inflight != 4'd0)) begin
                        r_flush_req <= 1'b1;
                    end
`endif
                end
                S_HOLD: begin
                    if (w_accept) begin
                        r_state   <= S_FILL;
                        r_valid   <= 1'b0;
                        r_count   <= 4'd0;
                        r_word    <= '0;
                        r_emitted <= r_emitted + 1'b1;
`ifdef PACKER_FLUSH_EN
                        r_word_bytes <= 4'd0;
`endif
                    end
                end
                default: r_state <= S_FILL;
            endcase
        end
    end

endmodule
